// File: rtl/rv32_pkg.sv
// Shared RV32 OF/EX types: forwarding packet, OF hold FSM states, OF->EX packet and operand helpers.
// Also used by builds that define OF_FWD_PERF_CNT_EN (counter width default lives here).
package rv32_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_REG_AW = 5;
  localparam int RV_CNT_W  = 32;

  typedef struct packed {
    logic [RV_XLEN-1:0] fwd_rs1_data;
    logic               fwd_rs1_enable;
    logic [RV_XLEN-1:0] fwd_rs2_data;
    logic               fwd_rs2_enable;
  } rv32_fwd_packet_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } of_hold_state_e;

  typedef struct packed {
    logic                 valid;
    logic [RV_XLEN-1:0]   rs1_val;
    logic [RV_XLEN-1:0]   rs2_val;
    logic [RV_REG_AW-1:0] rd;
    logic                 is_load;
  } rv32_of2ex_packet_t;

  // x0 is hard-wired to zero and is never replaced by forwarded data.
  function automatic logic fwd_selected(input logic [RV_REG_AW-1:0] sel, input logic fwd_en);
    return fwd_en && (sel != '0);
  endfunction

  function automatic logic [RV_XLEN-1:0] resolve_operand(input logic [RV_REG_AW-1:0] sel,
                                                         input logic                 fwd_en,
                                                         input logic [RV_XLEN-1:0]   fwd_data,
                                                         input logic [RV_XLEN-1:0]   rf_data);
    if (sel == '0) return '0;
    if (fwd_en) return fwd_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/of_operand_sel.sv
// One source operand: x0/forward/regfile select plus the skid-buffer copy refreshed by forwarding while held.
// With OF_FWD_PERF_CNT_EN defined it also reports whether the value came from the forwarding network.
module of_operand_sel
  import rv32_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int REG_AW = RV_REG_AW
) (
  input  logic              clk,
  input  logic [REG_AW-1:0] rs_sel_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [XLEN-1:0]   fwd_data_i,
  input  logic              fwd_en_i,
  input  logic              capture_i,
  input  logic              hold_i,
  output logic [XLEN-1:0]   res_val_o,
  output logic [XLEN-1:0]   buf_val_o
`ifdef OF_FWD_PERF_CNT_EN
  ,
  output logic              res_fwd_o,
  output logic              buf_fwd_o
`endif
);

  logic [REG_AW-1:0] sel_q;
  logic [XLEN-1:0]   val_q;
  logic              ovr;

  assign res_val_o = resolve_operand(rs_sel_i, fwd_en_i, fwd_data_i, rf_data_i);

  // While held, a producer finishing late still updates the parked operand; the same-cycle
  // value is bypassed so the release cycle already sees it.
  assign ovr       = hold_i && fwd_selected(sel_q, fwd_en_i);
  assign buf_val_o = ovr ? fwd_data_i : val_q;

  always_ff @(posedge clk) begin
    if (capture_i) begin
      sel_q <= rs_sel_i;
      val_q <= res_val_o;
    end else if (ovr) begin
      val_q <= fwd_data_i;
    end
  end

`ifdef OF_FWD_PERF_CNT_EN
  logic fwd_q;

  assign res_fwd_o = fwd_selected(rs_sel_i, fwd_en_i);
  assign buf_fwd_o = ovr || fwd_q;

  always_ff @(posedge clk) begin
    if (capture_i) begin
      fwd_q <= res_fwd_o;
    end else if (ovr) begin
      fwd_q <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/of_operand_stage.sv
// OF->EX pipeline register: operand resolve, load-use interlock, skid buffer for stall_ofex.
// Optional perf counters (cnt_fwd_rs1/2, cnt_loaduse) when OF_FWD_PERF_CNT_EN is defined.
module of_operand_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int REG_AW = RV_REG_AW
`ifdef OF_FWD_PERF_CNT_EN
  ,
  parameter int CNT_W  = RV_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rs1_sel,
  input  logic [REG_AW-1:0] in_rs2_sel,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  rv32_fwd_packet_t  fwd_packet,
  input  logic              stall_ofex,
  input  logic              flush,
  output logic              stall_req,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_is_load
`ifdef OF_FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_fwd_rs1,
  output logic [CNT_W-1:0]  cnt_fwd_rs2,
  output logic [CNT_W-1:0]  cnt_loaduse
`endif
);

  of_hold_state_e     state_q, state_d;
  rv32_of2ex_packet_t ex_q, ex_d;
  logic               buf_valid_q, buf_valid_d;
  logic [REG_AW-1:0]  buf_rd_q;
  logic               buf_is_load_q;

  logic               capture, load_in, load_buf, bubble, hold_mode;
  logic               hit_rs1, hit_rs2;
  logic [XLEN-1:0]    res_rs1, res_rs2, buf_rs1, buf_rs2;
`ifdef OF_FWD_PERF_CNT_EN
  logic               res_fwd1, res_fwd2, buf_fwd1, buf_fwd2;
`endif

  assign hold_mode = (state_q == HOLD);

  of_operand_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel_rs1 (
    .clk        (clk),
    .rs_sel_i   (in_rs1_sel),
    .rf_data_i  (rf_rs1_data),
    .fwd_data_i (fwd_packet.fwd_rs1_data),
    .fwd_en_i   (fwd_packet.fwd_rs1_enable),
    .capture_i  (capture),
    .hold_i     (hold_mode),
    .res_val_o  (res_rs1),
    .buf_val_o  (buf_rs1)
`ifdef OF_FWD_PERF_CNT_EN
    ,
    .res_fwd_o  (res_fwd1),
    .buf_fwd_o  (buf_fwd1)
`endif
  );

  of_operand_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel_rs2 (
    .clk        (clk),
    .rs_sel_i   (in_rs2_sel),
    .rf_data_i  (rf_rs2_data),
    .fwd_data_i (fwd_packet.fwd_rs2_data),
    .fwd_en_i   (fwd_packet.fwd_rs2_enable),
    .capture_i  (capture),
    .hold_i     (hold_mode),
    .res_val_o  (res_rs2),
    .buf_val_o  (buf_rs2)
`ifdef OF_FWD_PERF_CNT_EN
    ,
    .res_fwd_o  (res_fwd2),
    .buf_fwd_o  (buf_fwd2)
`endif
  );

  // A load in EX cannot forward its data yet; a dependent reader in OF must wait one cycle.
  assign hit_rs1   = in_uses_rs1 && (in_rs1_sel == ex_q.rd);
  assign hit_rs2   = in_uses_rs2 && (in_rs2_sel == ex_q.rd);
  assign stall_req = !reset && in_valid && ex_q.valid && ex_q.is_load &&
                     (ex_q.rd != '0) && (hit_rs1 || hit_rs2);

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    capture     = 1'b0;
    load_in     = 1'b0;
    load_buf    = 1'b0;
    bubble      = 1'b0;
    if (flush) begin
      state_d     = RUN;
      buf_valid_d = 1'b0;
    end else if (stall_ofex) begin
      if (state_q == RUN) begin
        capture     = 1'b1;
        buf_valid_d = in_valid;
        state_d     = HOLD;
      end
    end else if (stall_req) begin
      // Parked copy is dropped: upstream still presents the same instruction and it re-resolves.
      bubble      = 1'b1;
      buf_valid_d = 1'b0;
      state_d     = RUN;
    end else if (state_q == HOLD) begin
      load_buf    = 1'b1;
      buf_valid_d = 1'b0;
      state_d     = RUN;
    end else begin
      load_in = 1'b1;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (flush || bubble) begin
      ex_d.valid = 1'b0;
    end else if (load_buf) begin
      ex_d.valid   = buf_valid_q;
      ex_d.rs1_val = buf_rs1;
      ex_d.rs2_val = buf_rs2;
      ex_d.rd      = buf_rd_q;
      ex_d.is_load = buf_is_load_q;
    end else if (load_in) begin
      ex_d.valid   = in_valid;
      ex_d.rs1_val = res_rs1;
      ex_d.rs2_val = res_rs2;
      ex_d.rd      = in_rd;
      ex_d.is_load = in_is_load;
    end
  end

  // ---- OF -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      ex_q        <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_rd_q      <= in_rd;
      buf_is_load_q <= in_is_load;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_rs1_val = ex_q.rs1_val;
  assign ex_rs2_val = ex_q.rs2_val;
  assign ex_rd      = ex_q.rd;
  assign ex_is_load = ex_q.is_load;

`ifdef OF_FWD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_fwd_rs1_q, cnt_fwd_rs2_q, cnt_loaduse_q;
  logic             enter_fwd1, enter_fwd2;

  assign enter_fwd1 = (load_in && in_valid && res_fwd1) || (load_buf && buf_valid_q && buf_fwd1);
  assign enter_fwd2 = (load_in && in_valid && res_fwd2) || (load_buf && buf_valid_q && buf_fwd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_fwd_rs1_q <= '0;
      cnt_fwd_rs2_q <= '0;
      cnt_loaduse_q <= '0;
    end else begin
      if (enter_fwd1) cnt_fwd_rs1_q <= cnt_fwd_rs1_q + CNT_W'(1);
      if (enter_fwd2) cnt_fwd_rs2_q <= cnt_fwd_rs2_q + CNT_W'(1);
      if (bubble)     cnt_loaduse_q <= cnt_loaduse_q + CNT_W'(1);
    end
  end

  assign cnt_fwd_rs1 = cnt_fwd_rs1_q;
  assign cnt_fwd_rs2 = cnt_fwd_rs2_q;
  assign cnt_loaduse = cnt_loaduse_q;
`endif

endmodule
